// File: rtl/relational_flag_monitor_pkg.sv
// Shared types and helpers for the relational flag monitor: FSM state encoding
// and the comparator-flag consistency check.
package relational_flag_monitor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN_GT = 2'd1,
    ST_RUN_LT = 2'd2,
    ST_ALARM  = 2'd3
  } state_t;

  // Flags are consistent when exactly one primary relation holds and the
  // derived flags agree with it.
  function automatic logic flags_consistent(
    input logic eq,
    input logic neq,
    input logic gt,
    input logic lt,
    input logic gte,
    input logic lte
  );
    logic w_one_hot;
    w_one_hot = (eq ^ gt ^ lt) & ~(eq & gt & lt);
    return w_one_hot && (neq == ~eq) && (gte == (gt | eq)) && (lte == (lt | eq));
  endfunction

endpackage

// File: rtl/relational_flag_monitor_sat_counter.sv
// Saturating event counter with synchronous clear; holds at all-ones.
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (inc && (r_cnt != {CNT_W{1'b1}})) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign cnt = r_cnt;

endmodule

// File: rtl/relational_flag_monitor.sv
// Monitors comparator result flags: counts relations, tracks max A, flags
// inconsistent samples and raises an alarm on a long same-direction run.
module relational_flag_monitor
  import relational_flag_monitor_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int CNT_W   = 8,
  parameter int RUN_LEN = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             eq,
  input  logic             neq,
  input  logic             gt,
  input  logic             lt,
  input  logic             gte,
  input  logic             lte,
  output logic [CNT_W-1:0] eq_cnt,
  output logic [CNT_W-1:0] gt_cnt,
  output logic [CNT_W-1:0] lt_cnt,
  output logic [WIDTH-1:0] max_a,
  output logic             flag_err,
  output logic             run_alarm,
  output logic             run_dir
);

  localparam logic [3:0] RUN_LEN_C = 4'(RUN_LEN);

  state_t     r_state, w_state_nxt;
  logic [3:0] r_run_cnt, w_run_cnt_nxt, w_run_inc;
  logic       r_run_dir, w_run_dir_nxt;
  logic       r_run_alarm;
  logic [WIDTH-1:0] r_max_a;
  logic       r_flag_err;
  logic       w_accept, w_cons, w_take;
  logic       w_unused_b;

  // B only qualifies the flags upstream; nothing here depends on its value.
  assign w_unused_b = ^B;

  assign in_ready  = (r_state != ST_ALARM);
  assign w_accept  = in_valid & in_ready & ~clear;
  assign w_cons    = flags_consistent(eq, neq, gt, lt, gte, lte);
  assign w_take    = w_accept & w_cons;
  assign w_run_inc = r_run_cnt + 4'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_run_cnt   <= 4'd0;
      r_run_dir   <= 1'b0;
      r_run_alarm <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_run_cnt   <= w_run_cnt_nxt;
      r_run_dir   <= w_run_dir_nxt;
      r_run_alarm <= (w_state_nxt == ST_ALARM);
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_run_cnt_nxt = r_run_cnt;
    w_run_dir_nxt = r_run_dir;
    if (clear) begin
      w_state_nxt   = ST_IDLE;
      w_run_cnt_nxt = 4'd0;
      w_run_dir_nxt = 1'b0;
    end else if (w_take) begin
      case (r_state)
        ST_IDLE: begin
          if (gt) begin
            w_state_nxt   = ST_RUN_GT;
            w_run_cnt_nxt = 4'd1;
            w_run_dir_nxt = 1'b1;
          end else if (lt) begin
            w_state_nxt   = ST_RUN_LT;
            w_run_cnt_nxt = 4'd1;
            w_run_dir_nxt = 1'b0;
          end
        end
        ST_RUN_GT: begin
          if (gt) begin
            w_run_cnt_nxt = w_run_inc;
            w_state_nxt   = (w_run_inc == RUN_LEN_C) ? ST_ALARM : ST_RUN_GT;
          end else if (lt) begin
            w_state_nxt   = ST_RUN_LT;
            w_run_cnt_nxt = 4'd1;
            w_run_dir_nxt = 1'b0;
          end else begin
            w_state_nxt   = ST_IDLE;
            w_run_cnt_nxt = 4'd0;
          end
        end
        ST_RUN_LT: begin
          if (lt) begin
            w_run_cnt_nxt = w_run_inc;
            w_state_nxt   = (w_run_inc == RUN_LEN_C) ? ST_ALARM : ST_RUN_LT;
          end else if (gt) begin
            w_state_nxt   = ST_RUN_GT;
            w_run_cnt_nxt = 4'd1;
            w_run_dir_nxt = 1'b1;
          end else begin
            w_state_nxt   = ST_IDLE;
            w_run_cnt_nxt = 4'd0;
          end
        end
        default: begin
          w_state_nxt = ST_ALARM;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_max_a    <= '0;
      r_flag_err <= 1'b0;
    end else if (clear) begin
      r_max_a    <= '0;
      r_flag_err <= 1'b0;
    end else begin
      if (w_take && (A > r_max_a)) r_max_a <= A;
      if (w_accept && !w_cons)     r_flag_err <= 1'b1;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_eq_cnt (
    .clk(clk), .rst(rst), .clr(clear), .inc(w_take & eq), .cnt(eq_cnt)
  );
  sat_counter #(.CNT_W(CNT_W)) u_gt_cnt (
    .clk(clk), .rst(rst), .clr(clear), .inc(w_take & gt), .cnt(gt_cnt)
  );
  sat_counter #(.CNT_W(CNT_W)) u_lt_cnt (
    .clk(clk), .rst(rst), .clr(clear), .inc(w_take & lt), .cnt(lt_cnt)
  );

  assign max_a     = r_max_a;
  assign flag_err  = r_flag_err;
  assign run_alarm = r_run_alarm;
  assign run_dir   = r_run_dir;

endmodule

// File: tb/tb_relational_flag_monitor.sv
// Directed bench for relational_flag_monitor (WIDTH=4, CNT_W=2, RUN_LEN=3).
module tb_relational_flag_monitor;
  import relational_flag_monitor_pkg::*;

  logic       clk = 1'b0;
  logic       rst, clear, in_valid, in_ready;
  logic [3:0] A, B;
  logic       eq, neq, gt, lt, gte, lte;
  logic [1:0] eq_cnt, gt_cnt, lt_cnt;
  logic [3:0] max_a;
  logic       flag_err, run_alarm, run_dir;

  int n_cmp = 0;
  int n_err = 0;

  relational_flag_monitor #(.WIDTH(4), .CNT_W(2), .RUN_LEN(3)) dut (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .eq(eq), .neq(neq), .gt(gt), .lt(lt), .gte(gte), .lte(lte),
    .eq_cnt(eq_cnt), .gt_cnt(gt_cnt), .lt_cnt(lt_cnt), .max_a(max_a),
    .flag_err(flag_err), .run_alarm(run_alarm), .run_dir(run_dir)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // rel: 0 = eq, 1 = gt, 2 = lt; flags derived consistently
  task automatic smp(input logic [3:0] a, input logic [3:0] b, input int rel);
    A = a; B = b; in_valid = 1'b1;
    eq = (rel == 0); gt = (rel == 1); lt = (rel == 2);
    neq = ~eq; gte = gt | eq; lte = lt | eq;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    in_valid = 1'b0; clear = 1'b0;
    A = '0; B = '0; eq = 0; neq = 0; gt = 0; lt = 0; gte = 0; lte = 0;
  endtask

  task automatic do_clear();
    idle_in();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle_in();
    #12;
    chk("rst_eq_cnt", 32'(eq_cnt), 32'd0);
    chk("rst_gt_cnt", 32'(gt_cnt), 32'd0);
    chk("rst_max_a", 32'(max_a), 32'd0);
    chk("rst_flag_err", 32'(flag_err), 32'd0);
    chk("rst_alarm", 32'(run_alarm), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_run_dir", 32'(run_dir), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Mixed relations
    smp(4'd5, 4'd5, 0); step();
    chk("s1_state_idle", 32'(dut.r_state), 32'(ST_IDLE));
    smp(4'd3, 4'd7, 2); step();
    chk("s1_state_run_lt", 32'(dut.r_state), 32'(ST_RUN_LT));
    chk("s1_dir_lt", 32'(run_dir), 32'd0);
    smp(4'd9, 4'd2, 1); step();
    chk("s1_eq_cnt", 32'(eq_cnt), 32'd1);
    chk("s1_lt_cnt", 32'(lt_cnt), 32'd1);
    chk("s1_gt_cnt", 32'(gt_cnt), 32'd1);
    chk("s1_max_a", 32'(max_a), 32'd9);
    chk("s1_flag_err", 32'(flag_err), 32'd0);
    chk("s1_state_run_gt", 32'(dut.r_state), 32'(ST_RUN_GT));
    chk("s1_dir_gt", 32'(run_dir), 32'd1);

    // Run of three gt samples raises the alarm
    do_clear();
    chk("clr_gt_cnt", 32'(gt_cnt), 32'd0);
    chk("clr_max_a", 32'(max_a), 32'd0);
    chk("clr_state", 32'(dut.r_state), 32'(ST_IDLE));
    smp(4'd9, 4'd2, 1); step();
    smp(4'd8, 4'd1, 1); step();
    chk("s2_alarm_early", 32'(run_alarm), 32'd0);
    chk("s2_ready_early", 32'(in_ready), 32'd1);
    smp(4'd4, 4'd0, 1); step();
    chk("s2_alarm", 32'(run_alarm), 32'd1);
    chk("s2_ready_low", 32'(in_ready), 32'd0);
    chk("s2_gt_cnt", 32'(gt_cnt), 32'd3);
    smp(4'd15, 4'd1, 1); step(); step();
    chk("s2_held_max", 32'(max_a), 32'd9);
    chk("s2_held_alarm", 32'(run_alarm), 32'd1);
    chk("s2_held_state", 32'(dut.r_state), 32'(ST_ALARM));
    do_clear();
    chk("s2_clr_alarm", 32'(run_alarm), 32'd0);
    chk("s2_clr_ready", 32'(in_ready), 32'd1);
    chk("s2_clr_gt_cnt", 32'(gt_cnt), 32'd0);

    // Inconsistent flags
    smp(4'd6, 4'd6, 0); gt = 1'b1; gte = 1'b1; step();
    chk("s3_flag_err", 32'(flag_err), 32'd1);
    chk("s3_eq_cnt", 32'(eq_cnt), 32'd0);
    chk("s3_gt_cnt", 32'(gt_cnt), 32'd0);
    chk("s3_max_a", 32'(max_a), 32'd0);
    chk("s3_state", 32'(dut.r_state), 32'(ST_IDLE));
    idle_in(); step();
    chk("s3_sticky", 32'(flag_err), 32'd1);
    do_clear();
    chk("s3_clr_err", 32'(flag_err), 32'd0);

    // Saturation at 2^CNT_W-1
    for (int i = 0; i < 3; i++) begin smp(4'd4, 4'd4, 0); step(); end
    chk("s4_eq_cnt3", 32'(eq_cnt), 32'd3);
    for (int i = 0; i < 2; i++) begin smp(4'd4, 4'd4, 0); step(); end
    chk("s4_eq_sat", 32'(eq_cnt), 32'd3);

    // Clear beats a simultaneous valid sample
    smp(4'd2, 4'd8, 2); clear = 1'b1; step();
    idle_in();
    chk("s5_eq_cnt", 32'(eq_cnt), 32'd0);
    chk("s5_lt_cnt", 32'(lt_cnt), 32'd0);
    chk("s5_state", 32'(dut.r_state), 32'(ST_IDLE));
    chk("s5_max_a", 32'(max_a), 32'd0);

    // Asynchronous reset mid-run
    smp(4'd9, 4'd2, 1); step();
    smp(4'd8, 4'd1, 1); step();
    chk("s6_run_cnt2", 32'(dut.r_run_cnt), 32'd2);
    idle_in();
    #2 rst = 1'b1;
    #1;
    chk("s6_rst_gt_cnt", 32'(gt_cnt), 32'd0);
    chk("s6_rst_max_a", 32'(max_a), 32'd0);
    chk("s6_rst_state", 32'(dut.r_state), 32'(ST_IDLE));
    chk("s6_rst_dir", 32'(run_dir), 32'd0);
    chk("s6_rst_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    smp(4'd5, 4'd1, 1); step();
    chk("s6_run_cnt1", 32'(dut.r_run_cnt), 32'd1);
    chk("s6_state", 32'(dut.r_state), 32'(ST_RUN_GT));
    chk("s6_gt_cnt", 32'(gt_cnt), 32'd1);
    chk("s6_max_a", 32'(max_a), 32'd5);
    idle_in();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
